// File: rtl/ripple_slice_sequencer.sv
// rtl/ripple_slice_sequencer.sv - sequences an N*W-bit add through one external N-bit ripple adder
// One slice per clock, LSB first; the carry between slices lives in a register.
module ripple_slice_sequencer #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           cin,
    output logic [N-1:0]   slice_a,
    output logic [N-1:0]   slice_b,
    output logic           slice_ci,
    input  logic [N-1:0]   slice_sum,
    input  logic           slice_co,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*W-1:0] sum,
    output logic           cout,
    output logic           ovf
);

    localparam int KW  = (W > 1) ? $clog2(W) : 1;
    localparam int MSB = N*W - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [KW-1:0]  k;
    logic [N*W-1:0] a_reg;
    logic [N*W-1:0] b_reg;
    logic [N*W-1:0] sum_reg;
    logic           carry;
    logic           cout_reg;
    logic           ovf_reg;
    logic           last_slice;

    assign last_slice = (k == KW'(W - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_slice)  state_next = DONE;
            DONE:    if (res_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slice mux is fed only from captured registers, never from a/b/cin directly.
    always_comb begin
        start_ready = (state == IDLE);
        res_valid   = (state == DONE);
        slice_a     = '0;
        slice_b     = '0;
        slice_ci    = 1'b0;
        if (state == RUN) begin
            slice_ci = carry;
            for (int i = 0; i < W; i++) begin
                if (k == KW'(i)) begin
                    slice_a = a_reg[i*N +: N];
                    slice_b = b_reg[i*N +: N];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < W; i++) begin
                        if (k == KW'(i)) sum_reg[i*N +: N] <= slice_sum;
                    end
                    carry <= slice_co;
                    if (last_slice) begin
                        k        <= '0;
                        cout_reg <= slice_co;
                        // The top slice's sum MSB is the result MSB, so take it straight from the adder.
                        ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) && (slice_sum[N-1] != a_reg[MSB]);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_ripple_slice_sequencer.sv
// tb/tb_ripple_slice_sequencer.sv - table-driven bench for ripple_slice_sequencer with a behavioural 4-bit adder
module tb_ripple_slice_sequencer;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          cin;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic          slice_ci;
    logic [3:0]    slice_sum;
    logic          slice_co;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   sum;
    logic          cout;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_ci};

    ripple_slice_sequencer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
        .slice_sum(slice_sum), .slice_co(slice_co),
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  ci;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " start_ready"}, {31'd0, start_ready}, 32'd1);
        check({tag, " res_valid"},   {31'd0, res_valid},   32'd0);
        check({tag, " slices"},      {23'd0, slice_a, slice_b, slice_ci}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] ci_seen;
        string      tag;
        tag = $sformatf("vec%0d", idx);
        res_ready   = 1'b1;
        a           = v.a;
        b           = v.b;
        cin         = v.cin;
        start_valid = 1'b1;
        check({tag, " start_ready"}, {31'd0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
        a           = 16'h0;
        b           = 16'h0;
        cin         = 1'b0;
        for (int s = 0; s < W; s++) begin
            ci_seen[s] = slice_ci;
            if (s == W - 1) check({tag, " res_valid early"}, {31'd0, res_valid}, 32'd0);
            tick();
        end
        check({tag, " res_valid at 5 edges"}, {31'd0, res_valid}, 32'd1);
        check({tag, " sum"},  {16'd0, sum},  {16'd0, v.sum});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, v.cout});
        check({tag, " ovf"},  {31'd0, ovf},  {31'd0, v.ovf});
        check({tag, " slice_ci"}, {28'd0, ci_seen}, {28'd0, v.ci});
        tick();
        check({tag, " res_valid one cycle"}, {31'd0, res_valid}, 32'd0);
        check({tag, " sum hold"}, {16'd0, sum}, {16'd0, v.sum});
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b0001};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111};
        vecs[6] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0100};

        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = 16'h0;
        b           = 16'h0;
        cin         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        check("reset sum/cout/ovf", {14'd0, sum, cout, ovf}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Backpressure in DONE, with start_valid pulsed during RUN and DONE.
        res_ready   = 1'b0;
        a           = 16'h1111;
        b           = 16'h2222;
        cin         = 1'b0;
        start_valid = 1'b1;
        tick();
        a = 16'hAAAA;
        b = 16'hAAAA;
        for (int s = 0; s < W; s++) tick();
        check("bp res_valid", {31'd0, res_valid}, 32'd1);
        check("bp sum", {16'd0, sum}, 32'h3333);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp hold%0d", c), {14'd0, start_ready, res_valid, sum}, {14'd0, 2'b01, 16'h3333});
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        tick();
        check("bp release", {14'd0, start_ready, res_valid, sum}, {14'd0, 2'b10, 16'h3333});

        // Reset at slice k=2 aborts the operation.
        run_vec(vecs[0], 10);
        a           = 16'h1234;
        b           = 16'h4321;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("mid slice_a k=2", {28'd0, slice_a}, 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        check("midrst sum/cout/ovf", {14'd0, sum, cout, ovf}, 32'd0);

        // Reset dominates a simultaneous accept; no result may appear afterwards.
        begin
            int seen;
            seen        = 0;
            rst         = 1'b1;
            start_valid = 1'b1;
            a           = 16'h5555;
            tick();
            rst         = 1'b0;
            start_valid = 1'b0;
            for (int c = 0; c < W + 3; c++) begin
                if (res_valid) seen++;
                tick();
            end
            check("no res after reset", seen, 0);
        end
        run_vec('{16'h0101, 16'h0101, 1'b0, 16'h0202, 1'b0, 1'b0, 4'b0000}, 11);

        // Reset in DONE wins over a result handshake.
        res_ready   = 1'b0;
        a           = 16'h0F0F;
        b           = 16'h0101;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int s = 0; s < W; s++) tick();
        check("done before rst", {15'd0, res_valid, sum}, {15'd0, 1'b1, 16'h1010});
        rst       = 1'b1;
        res_ready = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("donerst");
        check("donerst sum", {16'd0, sum}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
